// File: rtl/filter_bank_pkg.sv
// Shared definitions for the filter bank sequencer: FSM encoding, index-width
// helper and the default geometry of the weight store.
package filter_bank_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_KSIZE       = 3;
  localparam int DEF_CHANNELS    = 3;
  localparam int DEF_NUM_FILTERS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } fsm_state_t;

  // Bits needed to index n items, never less than one.
  function automatic int idx_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/kernel_slice_sel.sv
// Combinational pick of one KSIZE x KSIZE kernel slice out of the flattened
// weight store. Storage layout: filter-major, then channel, row, column.
// An out-of-range (filter, chan) pair yields an all-zero slice.
module kernel_slice_sel
  import filter_bank_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int KSIZE       = DEF_KSIZE,
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int CW          = idx_width(CHANNELS),
  parameter int FW          = idx_width(NUM_FILTERS)
) (
  input  logic [NUM_FILTERS*CHANNELS*KSIZE*KSIZE*WIDTH-1:0] weights,
  input  logic [FW-1:0]                                     filter,
  input  logic [CW-1:0]                                     chan,
  output logic [KSIZE*KSIZE*WIDTH-1:0]                      slice
);

  localparam int SLICE_W = KSIZE * KSIZE * WIDTH;

  int slot;

  // Address the slice slot and extract it, guarding against stray indices.
  always_comb begin
    slot  = 0;
    slice = '0;
    if (32'(filter) < NUM_FILTERS && 32'(chan) < CHANNELS) begin
      slot  = 32'(filter) * CHANNELS + 32'(chan);
      slice = weights[slot*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/filter_bank_seq.sv
// Filter bank sequencer: stores NUM_FILTERS filters of KSIZE x KSIZE x CHANNELS
// weights and, on start, streams one channel slice per valid/ready handshake
// to the MAC array.
// Optional build macro FILTER_SWEEP_EN: start ignores filter_sel and streams
// every filter in order (all channels of each), with a single done at the end.
module filter_bank_seq
  import filter_bank_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int KSIZE       = DEF_KSIZE,
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter int CW          = idx_width(CHANNELS),
  parameter int FW          = idx_width(NUM_FILTERS),
  parameter int KW          = idx_width(KSIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [FW-1:0]                 wr_filter,
  input  logic [CW-1:0]                 wr_chan,
  input  logic [KW-1:0]                 wr_row,
  input  logic [KW-1:0]                 wr_col,
  input  logic [WIDTH-1:0]              wr_data,
  output logic                          wr_err,
  input  logic                          start,
  input  logic [FW-1:0]                 filter_sel,
  output logic                          busy,
  output logic                          done,
  output logic [KSIZE*KSIZE*WIDTH-1:0]  kernel_out,
  output logic [CW-1:0]                 out_chan,
  output logic [FW-1:0]                 out_filter,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int             SLICE_W = KSIZE * KSIZE * WIDTH;
  localparam int             TOTAL_W = NUM_FILTERS * CHANNELS * SLICE_W;
  localparam logic [CW-1:0]  LAST_C  = CW'(CHANNELS - 1);
  localparam logic [FW-1:0]  LAST_F  = FW'(NUM_FILTERS - 1);

  fsm_state_t              state;
  logic [TOTAL_W-1:0]      weights;

  logic                    wr_in_range;
  logic                    wr_ok;
  int                      wr_slot;

  logic [FW-1:0]           sel_filter;
  logic [CW-1:0]           sel_chan;
  logic [SLICE_W-1:0]      slice_sel;
  logic [SLICE_W-1:0]      slice_fwd;
  logic                    last_slice;

  // Write qualification: only in IDLE and only with every index in range.
  always_comb begin
    wr_in_range = (32'(wr_filter) < NUM_FILTERS) &&
                  (32'(wr_chan)   < CHANNELS)    &&
                  (32'(wr_row)    < KSIZE)       &&
                  (32'(wr_col)    < KSIZE);
    wr_ok       = wr_en && (state == IDLE) && wr_in_range;
    wr_slot     = ((32'(wr_filter) * CHANNELS + 32'(wr_chan)) * KSIZE
                   + 32'(wr_row)) * KSIZE + 32'(wr_col);
  end

  // Choose which (filter, chan) slice the output register loads next.
  always_comb begin
    sel_filter = out_filter;
    sel_chan   = out_chan + CW'(1);
    if (state == IDLE) begin
`ifdef FILTER_SWEEP_EN
      sel_filter = '0;
`else
      sel_filter = (32'(filter_sel) < NUM_FILTERS) ? filter_sel : '0;
`endif
      sel_chan   = '0;
    end
`ifdef FILTER_SWEEP_EN
    else if (out_chan == LAST_C) begin
      sel_filter = out_filter + FW'(1);
      sel_chan   = '0;
    end
`endif
  end

  // Final handshake of a run: last channel (of the last filter when sweeping).
  always_comb begin
`ifdef FILTER_SWEEP_EN
    last_slice = (out_chan == LAST_C) && (out_filter == LAST_F);
`else
    last_slice = (out_chan == LAST_C);
`endif
  end

  kernel_slice_sel #(
    .WIDTH       (WIDTH),
    .KSIZE       (KSIZE),
    .CHANNELS    (CHANNELS),
    .NUM_FILTERS (NUM_FILTERS),
    .CW          (CW),
    .FW          (FW)
  ) u_slice_sel (
    .weights (weights),
    .filter  (sel_filter),
    .chan    (sel_chan),
    .slice   (slice_sel)
  );

  // Forward a same-cycle write into the slice so start+write sees the new weight.
  always_comb begin
    slice_fwd = slice_sel;
    if (wr_ok && (wr_filter == sel_filter) && (wr_chan == sel_chan))
      slice_fwd[(32'(wr_row) * KSIZE + 32'(wr_col)) * WIDTH +: WIDTH] = wr_data;
  end

  // Weight store: cleared by reset, written one weight per accepted strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      weights <= '0;
    end else if (wr_ok) begin
      weights[wr_slot*WIDTH +: WIDTH] <= wr_data;
    end
  end

  // Rejected writes report one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
    end
  end

  // Streaming FSM with registered slice, index, valid, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kernel_out <= '0;
      out_chan   <= '0;
      out_filter <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= STREAM;
            out_valid  <= 1'b1;
            busy       <= 1'b1;
            out_filter <= sel_filter;
            out_chan   <= sel_chan;
            kernel_out <= slice_fwd;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (last_slice) begin
              state     <= DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_filter <= sel_filter;
              out_chan   <= sel_chan;
              kernel_out <= slice_fwd;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
